// File: rtl/fechadura_ctrl.sv
// fechadura_ctrl: lock/door state machine with code check,
// auto-lock, door-open bip and brute-force lockout timers.
package fechadura_pkg;
  typedef logic [19:0][3:0] senhaPac_t;
  typedef logic [5:0][3:0]  bcdPac_t;

  typedef struct packed {
    logic       bip_status;
    logic [6:0] bip_time;
    logic [6:0] tranca_aut_time;
    senhaPac_t  senha_master;
    senhaPac_t  senha_1;
    senhaPac_t  senha_2;
    senhaPac_t  senha_3;
    senhaPac_t  senha_4;
  } setupPac_t;

  localparam senhaPac_t SENHA_F = '1;
  localparam senhaPac_t SENHA_E = {20{4'hE}};
  localparam senhaPac_t SENHA_DEF = {{16{4'hF}}, 16'h1234};

  localparam setupPac_t CFG_DEF = '{
    bip_status:      1'b1,
    bip_time:        7'd5,
    tranca_aut_time: 7'd5,
    senha_master:    SENHA_DEF,
    senha_1:         SENHA_F,
    senha_2:         SENHA_F,
    senha_3:         SENHA_F,
    senha_4:         SENHA_F
  };
endpackage

module fechadura_ctrl
  import fechadura_pkg::*;
#(
  parameter int CLK_PER_SEC = 1000,
  parameter int MAX_TENT    = 5,
  parameter int LOCKOUT_S   = 30
) (
  input  logic      clk,
  input  logic      rst,
  input  senhaPac_t digitos_value,
  input  logic      digitos_valid,
  input  setupPac_t data_setup_new,
  input  logic      data_setup_ok,
  input  logic      sensor_contato,
  input  logic      botao_interno,
  output logic      setup_on,
  output logic      tranca,
  output logic      bip,
  output logic      display_en,
  output bcdPac_t   bcd_pac
);

  localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam int FW = $clog2(MAX_TENT + 1);

  typedef enum logic [2:0] {
    TRANCADO,
    DESTRAVADO,
    PORTA_ABERTA,
    SETUP,
    BLOQUEADO
  } state_t;

  state_t    state, state_nxt;
  setupPac_t cfg, cfg_nxt;
  logic [FW-1:0] fails, fails_nxt;
  logic [PW-1:0] presc;
  logic [6:0] secs;
  logic [6:0] remain;
  logic bip_r, bip_nxt;
  logic fresh;
  logic tick;
  logic code_ok, master_hit, user_hit, miss;

  // An all-F slot is an empty slot and must never open the lock.
  function automatic logic hit(input senhaPac_t a, input senhaPac_t s);
    return (a == s) && (s != SENHA_F);
  endfunction

  assign code_ok = digitos_valid
                && (digitos_value != SENHA_F)
                && (digitos_value != SENHA_E);
  assign master_hit = code_ok && hit(digitos_value, cfg.senha_master);
  assign user_hit = master_hit
                 || (code_ok && (hit(digitos_value, cfg.senha_1)
                              || hit(digitos_value, cfg.senha_2)
                              || hit(digitos_value, cfg.senha_3)
                              || hit(digitos_value, cfg.senha_4)));
  assign miss = code_ok && !user_hit;

  assign tick = (presc == PW'(CLK_PER_SEC - 1));

  always_comb begin
    state_nxt = state;
    fails_nxt = fails;
    cfg_nxt   = cfg;
    bip_nxt   = 1'b0;
    unique case (state)
      TRANCADO: begin
        if (botao_interno) begin
          state_nxt = DESTRAVADO;
          fails_nxt = '0;
        end else if (user_hit) begin
          state_nxt = DESTRAVADO;
          fails_nxt = '0;
        end else if (miss) begin
          fails_nxt = fails + FW'(1);
          if (fails_nxt == FW'(MAX_TENT)) begin
            state_nxt = BLOQUEADO;
          end
        end
      end
      DESTRAVADO: begin
        if (!sensor_contato) begin
          state_nxt = PORTA_ABERTA;
        end else if (botao_interno) begin
          state_nxt = TRANCADO;
        end else if (master_hit) begin
          state_nxt = SETUP;
        end else if (secs == cfg.tranca_aut_time) begin
          state_nxt = TRANCADO;
        end
      end
      PORTA_ABERTA: begin
        bip_nxt = bip_r
               || (cfg.bip_status && (secs == cfg.bip_time));
        if (sensor_contato) begin
          state_nxt = DESTRAVADO;
          bip_nxt   = 1'b0;
        end
      end
      SETUP: begin
        if (data_setup_ok) begin
          cfg_nxt   = data_setup_new;
          state_nxt = DESTRAVADO;
        end
      end
      BLOQUEADO: begin
        if (botao_interno) begin
          state_nxt = DESTRAVADO;
          fails_nxt = '0;
        end else if (secs == 7'(LOCKOUT_S)) begin
          state_nxt = TRANCADO;
          fails_nxt = '0;
        end
      end
      default: state_nxt = TRANCADO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= TRANCADO;
      cfg   <= CFG_DEF;
      fails <= '0;
      bip_r <= 1'b0;
      fresh <= 1'b0;
      presc <= '0;
      secs  <= '0;
    end else begin
      state <= state_nxt;
      cfg   <= cfg_nxt;
      fails <= fails_nxt;
      bip_r <= bip_nxt;
      fresh <= (state_nxt != state);
      // Every state starts its own timing window from zero.
      if (state_nxt != state) begin
        presc <= '0;
        secs  <= '0;
      end else if (tick) begin
        presc <= '0;
        if (secs != 7'h7F) begin
          secs <= secs + 7'd1;
        end
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  assign tranca = (state == TRANCADO) || (state == BLOQUEADO);
  assign bip = bip_r;
  assign setup_on = (state == SETUP) && fresh;
  assign display_en = (state == BLOQUEADO);
  assign remain = 7'(LOCKOUT_S) - secs;

  always_comb begin
    bcd_pac = {6{4'hB}};
    if (display_en) begin
      bcd_pac[1] = 4'(remain / 7'd10);
      bcd_pac[0] = 4'(remain % 7'd10);
    end
  end

endmodule

// File: tb/tb_fechadura_ctrl.sv
// tb_fechadura_ctrl: stimulus queues expected output changes,
// a negedge monitor pops and compares on every change.
module tb_fechadura_ctrl;
  import fechadura_pkg::*;

  localparam int CPS = 4;
  localparam logic [23:0] NB = 24'hBBBBBB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  senhaPac_t digitos_value;
  logic      digitos_valid;
  setupPac_t data_setup_new;
  logic      data_setup_ok;
  logic      sensor_contato;
  logic      botao_interno;
  logic      setup_on;
  logic      tranca;
  logic      bip;
  logic      display_en;
  bcdPac_t   bcd_pac;

  fechadura_ctrl #(
    .CLK_PER_SEC(CPS),
    .MAX_TENT(5),
    .LOCKOUT_S(30)
  ) dut (
    .clk(clk),
    .rst(rst),
    .digitos_value(digitos_value),
    .digitos_valid(digitos_valid),
    .data_setup_new(data_setup_new),
    .data_setup_ok(data_setup_ok),
    .sensor_contato(sensor_contato),
    .botao_interno(botao_interno),
    .setup_on(setup_on),
    .tranca(tranca),
    .bip(bip),
    .display_en(display_en),
    .bcd_pac(bcd_pac)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          at_q[$];
  logic [27:0] v_q[$];
  string       n_q[$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  bit done = 1'b0;
  bit final_chk = 1'b0;
  logic [27:0] prev = 'x;

  always @(negedge clk) begin
    logic [27:0] cur;
    int          e_at;
    logic [27:0] e_v;
    string       e_n;
    cur = {tranca, bip, setup_on, display_en, bcd_pac};
    if (mon_en && (cur !== prev)) begin
      checks++;
      if (at_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: got %h at cyc %0d", cur, cyc);
      end else begin
        e_at = at_q.pop_front();
        e_v  = v_q.pop_front();
        e_n  = n_q.pop_front();
        if ((cur !== e_v) || ((e_at >= 0) && (e_at != cyc))) begin
          errors++;
          $display("FAIL %s: got %h at cyc %0d, expected %h at cyc %0d",
                   e_n, cur, cyc, e_v, e_at);
        end
      end
      prev = cur;
    end
    if (done && !final_chk) begin
      final_chk = 1'b1;
      checks++;
      if (at_q.size() != 0) begin
        errors++;
        $display("FAIL pending: %0d expected changes not seen, next %s at cyc %0d",
                 at_q.size(), n_q[0], at_q[0]);
      end
    end
  end

  function automatic logic [27:0] ov(input logic t, input logic b,
                                     input logic s, input logic d,
                                     input logic [23:0] bcd);
    return {t, b, s, d, bcd};
  endfunction

  function automatic senhaPac_t code(input logic [15:0] d);
    return {{16{4'hF}}, d};
  endfunction

  function automatic logic [7:0] bcd2(input int v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  task automatic expect_at(input int at, input logic [27:0] v, input string n);
    at_q.push_back(at);
    v_q.push_back(v);
    n_q.push_back(n);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_code(input senhaPac_t c);
    digitos_value = c;
    digitos_valid = 1'b1;
    step();
    digitos_valid = 1'b0;
  endtask

  task automatic press();
    botao_interno = 1'b1;
    step();
    botao_interno = 1'b0;
  endtask

  logic [27:0] LK, UL;
  setupPac_t cfg_a, cfg_b;
  int k;

  initial begin
    LK = ov(1'b1, 1'b0, 1'b0, 1'b0, NB);
    UL = ov(1'b0, 1'b0, 1'b0, 1'b0, NB);
    cfg_a.bip_status      = 1'b1;
    cfg_a.bip_time        = 7'd5;
    cfg_a.tranca_aut_time = 7'd10;
    cfg_a.senha_master    = code(16'h1234);
    cfg_a.senha_1         = code(16'h0007);
    cfg_a.senha_2         = '1;
    cfg_a.senha_3         = '1;
    cfg_a.senha_4         = '1;
    cfg_b = cfg_a;
    cfg_b.bip_status      = 1'b0;
    cfg_b.tranca_aut_time = 7'd5;

    digitos_value  = '1;
    digitos_valid  = 1'b0;
    data_setup_new = '0;
    data_setup_ok  = 1'b0;
    sensor_contato = 1'b1;
    botao_interno  = 1'b0;

    step(3);
    rst = 1'b0;
    expect_at(-1, LK, "reset_state");
    mon_en = 1'b1;
    step(2);

    // master code unlocks, default auto-lock 5 s
    expect_at(cyc + 1, UL, "unlock_master");
    expect_at(cyc + 1 + 4 * 5 + 1, LK, "autolock_5s");
    send_code(code(16'h1234));
    step(25);

    // button beats master code in the same cycle
    expect_at(cyc + 1, UL, "btn_unlock");
    press();
    step(2);
    expect_at(cyc + 1, LK, "btn_over_master");
    digitos_value = code(16'h1234);
    digitos_valid = 1'b1;
    botao_interno = 1'b1;
    step();
    digitos_valid = 1'b0;
    botao_interno = 1'b0;
    step(3);

    // four misses, two ignored patterns, fifth miss locks out
    for (int i = 0; i < 4; i++) begin
      send_code(code(16'h9999));
      step();
    end
    send_code('1);
    step();
    send_code({20{4'hE}});
    step();
    k = cyc;
    expect_at(k + 1, ov(1'b1, 1'b0, 1'b0, 1'b1, {16'hBBBB, 8'h30}), "lockout_enter");
    for (int n = 1; n <= 30; n++) begin
      expect_at(k + 1 + 4 * n,
                ov(1'b1, 1'b0, 1'b0, 1'b1, {16'hBBBB, bcd2(30 - n)}),
                $sformatf("lockout_bcd_%0d", 30 - n));
    end
    expect_at(k + 1 + 4 * 30 + 1, LK, "lockout_end");
    send_code(code(16'h9999));
    step(10);
    send_code(code(16'h1234));
    step(114);

    expect_at(cyc + 1, UL, "unlock_after_lockout");
    send_code(code(16'h1234));
    step(2);
    expect_at(cyc + 1, LK, "btn_lock");
    press();
    step(2);

    // door open: bip at 5 s, close clears bip and restarts auto-lock
    expect_at(cyc + 1, UL, "unlock_door");
    send_code(code(16'h1234));
    step(2);
    k = cyc;
    sensor_contato = 1'b0;
    expect_at(k + 1 + 4 * 5 + 1, ov(1'b0, 1'b1, 1'b0, 1'b0, NB), "bip_on_5s");
    step(5);
    press();
    send_code(code(16'h1234));
    step(30);
    expect_at(cyc + 1, UL, "door_close_bip_off");
    expect_at(cyc + 1 + 4 * 5 + 1, LK, "autolock_after_close");
    sensor_contato = 1'b1;
    step(25);

    // commit outside SETUP ignored; new user code still a miss
    data_setup_new = cfg_a;
    data_setup_ok = 1'b1;
    step();
    data_setup_ok = 1'b0;
    send_code(code(16'h0007));
    step();
    expect_at(cyc + 1, UL, "unlock_pre_setup");
    send_code(code(16'h1234));
    step();
    expect_at(cyc + 1, ov(1'b0, 1'b0, 1'b1, 1'b0, NB), "setup_on_rise");
    expect_at(cyc + 2, UL, "setup_on_fall");
    send_code(code(16'h1234));
    step(4);
    k = cyc;
    expect_at(k + 1 + 4 * 10 + 1, LK, "autolock_10s");
    data_setup_ok = 1'b1;
    step();
    data_setup_ok = 1'b0;
    step(45);
    expect_at(cyc + 1, UL, "unlock_user1");
    send_code(code(16'h0007));
    step(3);
    expect_at(cyc + 1, LK, "btn_lock_user1");
    press();
    step(2);

    // bip disabled: long door-open stays quiet
    expect_at(cyc + 1, UL, "unlock_user1_b");
    send_code(code(16'h0007));
    step();
    expect_at(cyc + 1, ov(1'b0, 1'b0, 1'b1, 1'b0, NB), "setup2_on_rise");
    expect_at(cyc + 2, UL, "setup2_on_fall");
    send_code(code(16'h1234));
    step(3);
    data_setup_new = cfg_b;
    data_setup_ok = 1'b1;
    step();
    data_setup_ok = 1'b0;
    sensor_contato = 1'b0;
    step(250);
    expect_at(cyc + 1 + 4 * 5 + 1, LK, "autolock_after_quiet_door");
    sensor_contato = 1'b1;
    step(25);

    // door opens in the same cycle auto-lock expires
    k = cyc;
    expect_at(k + 1, UL, "unlock_race");
    send_code(code(16'h1234));
    step(20);
    sensor_contato = 1'b0;
    step(10);
    expect_at(cyc + 1 + 4 * 5 + 1, LK, "autolock_after_race");
    sensor_contato = 1'b1;
    step(25);

    // reset inside SETUP restores default config
    expect_at(cyc + 1, UL, "unlock_pre_rst");
    send_code(code(16'h1234));
    step();
    expect_at(cyc + 1, ov(1'b0, 1'b0, 1'b1, 1'b0, NB), "setup3_on_rise");
    expect_at(cyc + 2, UL, "setup3_on_fall");
    send_code(code(16'h1234));
    step(2);
    expect_at(cyc, LK, "rst_in_setup");
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(2);
    send_code(code(16'h0007));
    step(2);
    expect_at(cyc + 1, UL, "master_default_after_rst");
    send_code(code(16'h1234));
    step(2);
    expect_at(cyc + 1, LK, "btn_lock_final");
    press();
    step(3);

    done = 1'b1;
    step(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
